// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader: FSM states,
// frame width, CFG_DATA field offsets and error codes.
package clb_cfg_pkg;

  localparam int CFG_W = 37;

  // LSB positions of the CFG_DATA fields
  localparam int CFG_MUX2_LSB    = 35;
  localparam int CFG_MUX3_LSB    = 33;
  localparam int CFG_MUX4_LSB    = 31;
  localparam int CFG_MUX5_LSB    = 29;
  localparam int CFG_MUX6_LSB    = 27;
  localparam int CFG_LUT_LSB     = 11;
  localparam int CFG_COMBOPT_LSB = 9;
  localparam int CFG_O2M_LSB     = 3;
  localparam int CFG_DQMUX_LSB   = 1;
  localparam int CFG_FLOP_LSB    = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CNT = 2'b01;
  localparam logic [1:0] ERR_PARITY  = 2'b10;
  localparam logic [1:0] ERR_STOP    = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LEN,
    ST_WAITS,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/clb_cfg_shift.sv
// Serial-in MSB-first shift register with saturating bit counter.
// last = the next shifted bit completes W bits; shifts only when en, clr resets the count.
module clb_cfg_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] dat,
  output logic [W-1:0] nxt,
  output logic         last,
  output logic         full
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  assign nxt  = {dat[W-2:0], din};
  assign last = (cnt >= CW'(W - 1));
  assign full = (cnt == CW'(W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      dat <= nxt;
      if (!full) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: preamble hunt, frame count, one 37-bit frame per CLB.
// CFG_WE one cycle after the stop-bit edge; DVALID=0 holds state. Optional parity: CLB_CFG_PARITY_EN.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int         NUM_CLB  = 4,
  parameter int         ADDR_W   = 2,
  parameter logic [7:0] PREAMBLE = 8'hF2
) (
  input  logic              K,
  input  logic              RST_N,
  input  logic              DIN,
  input  logic              DVALID,
  input  logic              PROG,
  output logic              CFG_WE,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        ERR_CODE
);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] code_q, code_d;

  logic             win_en, len_en, frm_en, win_clr, len_clr, frm_clr;
  logic [7:0]       win_dat, win_nxt, len_dat, len_nxt;
  logic [CFG_W-1:0] frm_dat, frm_nxt;
  logic             win_last, len_last, frm_last, win_full, len_full, frm_full;

  clb_cfg_shift #(.W(8)) u_win (
    .clk(K), .rst_n(RST_N), .clr(win_clr), .en(win_en), .din(DIN),
    .dat(win_dat), .nxt(win_nxt), .last(win_last), .full(win_full)
  );

  clb_cfg_shift #(.W(8)) u_len (
    .clk(K), .rst_n(RST_N), .clr(len_clr), .en(len_en), .din(DIN),
    .dat(len_dat), .nxt(len_nxt), .last(len_last), .full(len_full)
  );

  clb_cfg_shift #(.W(CFG_W)) u_frm (
    .clk(K), .rst_n(RST_N), .clr(frm_clr), .en(frm_en), .din(DIN),
    .dat(frm_dat), .nxt(frm_nxt), .last(frm_last), .full(frm_full)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, win_dat, win_full, len_full, frm_full, frm_nxt};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    win_en  = 1'b0;
    len_en  = 1'b0;
    frm_en  = 1'b0;
    win_clr = 1'b0;
    len_clr = 1'b0;
    frm_clr = 1'b0;
    // PROG wins over any bit presented in the same cycle
    if (PROG) begin
      state_d = ST_HUNT;
      idx_d   = '0;
      code_d  = ERR_NONE;
      win_clr = 1'b1;
      len_clr = 1'b1;
      frm_clr = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: if (DVALID) begin
          win_en = 1'b1;
          if (win_last && win_nxt == PREAMBLE) state_d = ST_LEN;
        end
        ST_LEN: if (DVALID) begin
          len_en = 1'b1;
          if (len_last) begin
            if (len_nxt == 8'd0 || len_nxt > 8'(NUM_CLB)) begin
              state_d = ST_ERR;
              code_d  = ERR_BAD_CNT;
            end else begin
              state_d = ST_WAITS;
              idx_d   = '0;
            end
          end
        end
        ST_WAITS: if (DVALID && !DIN) begin
          state_d = ST_DATA;
          frm_clr = 1'b1;
        end
        ST_DATA: if (DVALID) begin
          frm_en = 1'b1;
`ifdef CLB_CFG_PARITY_EN
          if (frm_last) state_d = ST_PAR;
`else
          if (frm_last) state_d = ST_STOP;
`endif
        end
`ifdef CLB_CFG_PARITY_EN
        ST_PAR: if (DVALID) begin
          if ((^frm_dat) ^ DIN) begin
            state_d = ST_ERR;
            code_d  = ERR_PARITY;
          end else begin
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: if (DVALID) begin
          if (DIN) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_ERR;
            code_d  = ERR_STOP;
          end
        end
        ST_WRITE: begin
          if (idx_q == len_dat - 8'd1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAITS;
            idx_d   = idx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are flops decoded from the next state, so CFG_WE cannot glitch
  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      code_q   <= ERR_NONE;
      CFG_WE   <= 1'b0;
      CFG_ADDR <= '0;
      CFG_DATA <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      CFG_WE  <= (state_d == ST_WRITE);
      if (state_d == ST_WRITE) begin
        CFG_ADDR <= idx_q[ADDR_W-1:0];
        CFG_DATA <= frm_dat;
      end
      BUSY <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
      DONE <= (state_d == ST_DONE);
      ERR  <= (state_d == ST_ERR);
    end
  end

  assign ERR_CODE = code_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized bench for clb_cfg_loader against a stream-parsing reference model.
module tb_clb_cfg_loader;

  localparam int NUM_CLB = 4;
  localparam int ADDR_W  = 2;
`ifdef CLB_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              K = 1'b0;
  logic              RST_N, DIN, DVALID, PROG;
  logic              CFG_WE, BUSY, DONE, ERR;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic [36:0]       CFG_DATA;
  logic [1:0]        ERR_CODE;

  clb_cfg_loader #(.NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W), .PREAMBLE(8'hF2)) dut (
    .K(K), .RST_N(RST_N), .DIN(DIN), .DVALID(DVALID), .PROG(PROG),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 K = ~K;

  int          n_checks = 0;
  int          n_errors = 0;
  int          vld_mode = 0;
  bit          stream[$];
  logic [44:0] obs_q[$];
  logic [44:0] exp_q[$];
  bit          exp_done, exp_err;
  logic [1:0]  exp_code;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge K) if (RST_N === 1'b1 && CFG_WE === 1'b1) obs_q.push_back({8'(CFG_ADDR), CFG_DATA});

  // Reference: parse the valid-bit stream seen after PROG and list the writes it implies
  task automatic run_model();
    int p = 0;
    int cnt = 0;
    bit found = 0;
    logic [7:0]  w = '0;
    logic [36:0] d;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_code = 2'b00;
    while (p < stream.size() && !found) begin
      w = {w[6:0], stream[p]};
      p++;
      if (p >= 8 && w == 8'hF2) found = 1;
    end
    if (!found || p + 8 > stream.size()) return;
    for (int i = 0; i < 8; i++) cnt = cnt * 2 + int'(stream[p++]);
    if (cnt == 0 || cnt > NUM_CLB) begin
      exp_err = 1; exp_code = 2'b01; return;
    end
    for (int f = 0; f < cnt; f++) begin
      while (p < stream.size() && stream[p] == 1'b1) p++;
      if (p + 38 > stream.size()) return;
      p++;
      d = '0;
      for (int i = 0; i < 37; i++) d = {d[35:0], stream[p++]};
      if (PAR_EN) begin
        if (p >= stream.size()) return;
        if ((^d) ^ stream[p++]) begin exp_err = 1; exp_code = 2'b10; return; end
      end
      if (p >= stream.size()) return;
      if (!stream[p++]) begin exp_err = 1; exp_code = 2'b11; return; end
      exp_q.push_back({8'(f), d});
    end
    exp_done = 1;
  endtask

  task automatic add_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic new_stream(input logic [7:0] cnt);
    stream.delete();
    add_bits(64'hF, 4);
    add_bits(64'hF2, 8);
    add_bits(64'(cnt), 8);
  endtask

  task automatic add_frame(input logic [36:0] d, input bit flip, input bit bad_stop);
    logic [36:0] dd;
    dd = flip ? (d ^ (37'd1 << $urandom_range(0, 36))) : d;
    add_bits(64'b110, 3);
    add_bits(64'(dd), 37);
    if (PAR_EN) stream.push_back(^d);
    stream.push_back(!bad_stop);
  endtask

  task automatic send_bit(input bit b);
    if (vld_mode == 1 || (vld_mode == 2 && $urandom_range(0, 3) == 0)) begin
      DVALID = 1'b0; DIN = 1'($urandom_range(0, 1));
      @(negedge K);
    end
    DVALID = 1'b1; DIN = b;
    @(negedge K);
    DVALID = 1'b0;
  endtask

  task automatic pulse_prog();
    obs_q.delete();
    PROG = 1'b1; DVALID = 1'($urandom_range(0, 1)); DIN = 1'($urandom_range(0, 1));
    @(negedge K);
    PROG = 1'b0; DVALID = 1'b0;
  endtask

  task automatic run_stream(input string tag, input bit do_prog);
    add_bits(64'b11, 2);
    run_model();
    if (do_prog) pulse_prog();
    foreach (stream[i]) send_bit(stream[i]);
    DVALID = 1'b0;
    repeat (4) @(negedge K);
    check({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({tag, ".addr"}, 64'(obs_q[i][44:37]), 64'(exp_q[i][44:37]));
      check({tag, ".data"}, 64'(obs_q[i][36:0]), 64'(exp_q[i][36:0]));
    end
    check({tag, ".done"}, 64'(DONE), 64'(exp_done));
    check({tag, ".err"}, 64'(ERR), 64'(exp_err));
    check({tag, ".code"}, 64'(ERR_CODE), 64'(exp_code));
    check({tag, ".busy"}, 64'(BUSY), 64'(!exp_done && !exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"}, 64'(CFG_WE), 64'd0);
    check({tag, ".addr"}, 64'(CFG_ADDR), 64'd0);
    check({tag, ".data"}, 64'(CFG_DATA), 64'd0);
    check({tag, ".busy"}, 64'(BUSY), 64'd0);
    check({tag, ".done"}, 64'(DONE), 64'd0);
    check({tag, ".err"}, 64'(ERR), 64'd0);
    check({tag, ".code"}, 64'(ERR_CODE), 64'd0);
  endtask

  initial begin
    RST_N = 1'b0; PROG = 1'b0; DIN = 1'b0; DVALID = 1'b0;
    repeat (2) @(negedge K);
    check_all_zero("rst");
    RST_N = 1'b1;
    repeat (2) @(negedge K);
    check("idle.busy", 64'(BUSY), 64'd0);

    // Two-frame load with fixed data
    new_stream(8'd2);
    add_frame(37'h0000000116, 0, 0);
    add_frame(37'h1FFFFFFFFF, 0, 0);
    run_stream("two", 1);
    check("two.d0", 64'(obs_q[0][36:0]), 64'h0000000116);
    check("two.d1", 64'(obs_q[1][36:0]), 64'h1FFFFFFFFF);
    check("two.a1", 64'(obs_q[1][44:37]), 64'd1);
    check("two.done", 64'(DONE), 64'd1);

    // Bad counts
    new_stream(8'd0);
    run_stream("cnt0", 1);
    check("cnt0.code", 64'(ERR_CODE), 64'd1);
    new_stream(8'd5);
    run_stream("cnt5", 1);
    check("cnt5.code", 64'(ERR_CODE), 64'd1);

    // Flipped data bit (parity error when compiled in)
    new_stream(8'd2);
    add_frame(37'h0ABCDE1234, 0, 0);
    add_frame(37'h1234567890, 1, 0);
    run_stream("flip", 1);

    // Bad stop bit, then PROG clears the error and hunting restarts
    new_stream(8'd1);
    add_frame(37'h0055AA55AA, 0, 1);
    run_stream("stop", 1);
    check("stop.code", 64'(ERR_CODE), 64'd3);
    pulse_prog();
    check("reprog.err", 64'(ERR), 64'd0);
    check("reprog.code", 64'(ERR_CODE), 64'd0);
    check("reprog.busy", 64'(BUSY), 64'd1);

    // DVALID toggling every cycle
    vld_mode = 1;
    new_stream(8'd1);
    add_frame(37'h1DEADBEEF5, 0, 0);
    run_stream("tog", 0);
    check("tog.data", 64'(CFG_DATA), 64'h1DEADBEEF5);
    vld_mode = 0;

    // Abort after 20 data bits of frame 1, then a full stream without another PROG
    new_stream(8'd2);
    add_bits(64'b110, 3);
    add_bits(64'(20'hA5A5A), 20);
    pulse_prog();
    foreach (stream[i]) send_bit(stream[i]);
    pulse_prog();
    repeat (3) @(negedge K);
    check("abort.nwr", 64'(obs_q.size()), 64'd0);
    check("abort.busy", 64'(BUSY), 64'd1);
    new_stream(8'd2);
    add_frame(37'h0F0F0F0F0F, 0, 0);
    add_frame(37'h1111111111, 0, 0);
    run_stream("reload", 0);

    // Randomized streams
    for (int it = 0; it < 10; it++) begin
      int cnt;
      vld_mode = $urandom_range(0, 2);
      cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(1, NUM_CLB);
      new_stream(8'(cnt));
      for (int f = 0; f < cnt && f < NUM_CLB; f++)
        add_frame(37'({$urandom(), $urandom()}), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      run_stream($sformatf("rnd%0d", it), 1);
    end
    vld_mode = 0;

    // Reset mid-frame: outputs clear immediately
    new_stream(8'd1);
    add_bits(64'b110, 3);
    add_bits(64'h3FF, 10);
    pulse_prog();
    foreach (stream[i]) send_bit(stream[i]);
    #2 RST_N = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge K);
    RST_N = 1'b1;
    @(negedge K);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
